// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one data memory between the pipeline MEM stage (core port) and an
//   external loader/debug port (ext port). The core has fixed priority. The ext
//   port is served in cycles where the core makes no access. Every ext
//   transaction is a grant cycle followed by a response cycle (RESP), in which
//   ext_rvalid_o pulses. Writes get this pulse too, as an acknowledge.
//
//   Optional feature, macro ARB_STARVE_GUARD_EN:
//     When defined, a wait counter tracks ext cycles that are blocked by the
//     core. After MAX_WAIT blocked cycles, a FORCE slot grants ext and stalls
//     the pipeline. When undefined, ext can be starved indefinitely and
//     core_stall_o is tied to 0.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   core_we_i / core_re_i     MEM-stage store / load
//   core_addr_i, core_wdata_i MEM-stage address / store data
//   core_rdata_o              load data (memory read data passed straight through)
//   core_stall_o              freeze F/D/E/M this cycle
//   ext_req_i, ext_we_i       ext request (held until grant), 1 = write
//   ext_addr_i, ext_wdata_i   ext address / write data
//   ext_gnt_o                 ext access performed on memory this cycle (comb)
//   ext_rvalid_o, ext_rdata_o registered response pulse / read data
//   mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i  memory port (write on clock edge, comb read)
// -----------------------------------------------------------------------------
//  state  | meaning
//  IDLE   | core owns memory; ext granted when the core is idle
//  RESP   | ext response cycle (rvalid), core owns memory, no ext grant
//  FORCE  | guard build only: ext forced onto memory, core stalled
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_we_i,
  input  logic              core_re_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_stall_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_gnt_o,
  output logic              ext_rvalid_o,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1
`ifdef ARB_STARVE_GUARD_EN
    ,
    ST_FORCE = 2'd2
`endif
  } state_e;

  state_e state_q, state_d;

  logic              core_req;
  logic              ext_gnt;
  logic              core_stall;
  logic              ext_rvalid_q;
  logic [DATA_W-1:0] ext_rdata_q;

  assign core_req = core_we_i | core_re_i;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  // MAX_WAIT only matters in the guard build.
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT == 0);
`endif

  always_comb begin
    state_d    = state_q;
    ext_gnt    = 1'b0;
    core_stall = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ext_req_i && !core_req) begin
          ext_gnt = 1'b1;
          state_d = ST_RESP;
        end
`ifdef ARB_STARVE_GUARD_EN
        if (!ext_req_i || !core_req) begin
          // request gone or granted this cycle
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_FORCE;
          end
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
`ifdef ARB_STARVE_GUARD_EN
        if (!ext_req_i) begin
          wait_cnt_d = '0;
        end
`endif
      end
`ifdef ARB_STARVE_GUARD_EN
      ST_FORCE: begin
        wait_cnt_d = '0;
        // a request withdrawn in the forced slot just returns to IDLE
        if (ext_req_i) begin
          ext_gnt    = 1'b1;
          core_stall = core_req;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      ext_rvalid_q <= ext_gnt;
      if (ext_gnt && !ext_we_i) begin
        ext_rdata_q <= mem_rdata_i;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  // The memory port goes to ext only in a grant cycle. A stalled core store
  // is dropped; the frozen pipeline presents it again later.
  always_comb begin
    if (ext_gnt) begin
      mem_we_o    = ext_we_i;
      mem_addr_o  = ext_addr_i;
      mem_wdata_o = ext_wdata_i;
    end else begin
      mem_we_o    = core_we_i & ~core_stall;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end
  end

  assign core_rdata_o = mem_rdata_i;
  assign ext_gnt_o    = ext_gnt;
  assign ext_rvalid_o = ext_rvalid_q;
  assign ext_rdata_o  = ext_rdata_q;

`ifdef ARB_STARVE_GUARD_EN
  assign core_stall_o = core_stall;
`else
  assign core_stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_we, core_re;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .core_we_i   (core_we),
    .core_re_i   (core_re),
    .core_addr_i (core_addr),
    .core_wdata_i(core_wdata),
    .core_rdata_o(core_rdata),
    .core_stall_o(core_stall),
    .ext_req_i   (ext_req),
    .ext_we_i    (ext_we),
    .ext_addr_i  (ext_addr),
    .ext_wdata_i (ext_wdata),
    .ext_gnt_o   (ext_gnt),
    .ext_rvalid_o(ext_rvalid),
    .ext_rdata_o (ext_rdata),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // small word memory: write on clock edge, combinational read
  logic [31:0] mem_model [0:127];
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr[8:2]] <= mem_wdata;
  end
  assign mem_rdata = mem_model[mem_addr[8:2]];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_core(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    core_we = we; core_re = re; core_addr = a; core_wdata = d;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gnt_cnt;
    int stall_cnt;
    rst_n = 1'b0;
    set_core(0, 0, 32'h0, 32'h0);
    set_ext(0, 0, 32'h0, 32'h0);
    #3;
    check_val("rst_rvalid", ext_rvalid, 0);
    check_val("rst_rdata", ext_rdata, 32'h0);
    check_val("rst_gnt", ext_gnt, 0);
    check_val("rst_stall", core_stall, 0);
    check_val("rst_mem_we", mem_we, 0);
    mid();
    rst_n = 1'b1;

    // ext write then read-back of 0x100 with the core idle
    next_cyc();
    set_ext(1, 1, 32'h100, 32'hDEADBEEF);
    mid();
    check_val("t1_gnt", ext_gnt, 1);
    check_val("t1_mem_we", mem_we, 1);
    check_val("t1_mem_addr", mem_addr, 32'h100);
    check_val("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check_val("t1_rvalid_early", ext_rvalid, 0);
    next_cyc();
    set_ext(0, 0, 32'h0, 32'h0);
    mid();
    check_val("t1_wack", ext_rvalid, 1);
    check_val("t1_resp_gnt", ext_gnt, 0);
    next_cyc();
    set_ext(1, 0, 32'h100, 32'h0);
    mid();
    check_val("t1_rd_gnt", ext_gnt, 1);
    check_val("t1_rd_mem_we", mem_we, 0);
    next_cyc();
    set_ext(0, 0, 32'h0, 32'h0);
    mid();
    check_val("t1_rd_rvalid", ext_rvalid, 1);
    check_val("t1_rd_rdata", ext_rdata, 32'hDEADBEEF);
    next_cyc();
    mid();
    check_val("t1_rvalid_pulse", ext_rvalid, 0);

    // preload 0x4 through the ext port
    next_cyc();
    set_ext(1, 1, 32'h4, 32'h12345678);
    next_cyc();
    set_ext(0, 0, 32'h0, 32'h0);
    next_cyc();

    // core store collides with ext read: core wins, ext granted next idle cycle
    set_core(1, 0, 32'h0, 32'h55);
    set_ext(1, 0, 32'h4, 32'h0);
    mid();
    check_val("t2_gnt_blocked", ext_gnt, 0);
    check_val("t2_core_we", mem_we, 1);
    check_val("t2_core_addr", mem_addr, 32'h0);
    check_val("t2_core_wdata", mem_wdata, 32'h55);
    next_cyc();
    set_core(0, 0, 32'h0, 32'h0);
    mid();
    check_val("t2_gnt", ext_gnt, 1);
    check_val("t2_ext_addr", mem_addr, 32'h4);
    next_cyc();
    set_ext(0, 0, 32'h0, 32'h0);
    mid();
    check_val("t2_rvalid", ext_rvalid, 1);
    check_val("t2_rdata", ext_rdata, 32'h12345678);
    next_cyc();
    set_core(0, 1, 32'h0, 32'h0);
    mid();
    check_val("t2_core_load", core_rdata, 32'h55);
    check_val("t2_load_no_we", mem_we, 0);
    next_cyc();
    set_core(0, 0, 32'h0, 32'h0);

    // ext_req held over idle-core cycles: grant pattern 1,0,1
    set_ext(1, 0, 32'h100, 32'h0);
    mid();
    check_val("t6_gnt0", ext_gnt, 1);
    next_cyc();
    mid();
    check_val("t6_gnt1", ext_gnt, 0);
    check_val("t6_rvalid1", ext_rvalid, 1);
    next_cyc();
    mid();
    check_val("t6_gnt2", ext_gnt, 1);
    next_cyc();
    set_ext(0, 0, 32'h0, 32'h0);
    mid();
    check_val("t6_rvalid3", ext_rvalid, 1);
    check_val("t6_rdata3", ext_rdata, 32'hDEADBEEF);
    next_cyc();

`ifdef ARB_STARVE_GUARD_EN
    // busy core starves ext: forced slot in cycle 5
    set_core(1, 0, 32'h20, 32'hAAAA5555);
    set_ext(1, 0, 32'h4, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      mid();
      check_val($sformatf("t3_gnt_c%0d", i), ext_gnt, 0);
      check_val($sformatf("t3_stall_c%0d", i), core_stall, 0);
      check_val($sformatf("t3_we_c%0d", i), mem_we, 1);
      next_cyc();
    end
    mid();
    check_val("t3_force_gnt", ext_gnt, 1);
    check_val("t3_force_stall", core_stall, 1);
    check_val("t3_force_no_store", mem_we, 0);
    check_val("t3_force_addr", mem_addr, 32'h4);
    next_cyc();
    set_ext(0, 0, 32'h0, 32'h0);
    mid();
    check_val("t3_resp_gnt", ext_gnt, 0);
    check_val("t3_resp_stall", core_stall, 0);
    check_val("t3_resp_rvalid", ext_rvalid, 1);
    check_val("t3_resp_rdata", ext_rdata, 32'h12345678);
    check_val("t3_resp_we", mem_we, 1);
    check_val("t3_core_store", mem_model[8], 32'hAAAA5555);
    next_cyc();
    // request withdrawn in the forced slot
    set_ext(1, 0, 32'h4, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      mid();
      next_cyc();
    end
    set_ext(0, 0, 32'h0, 32'h0);
    mid();
    check_val("t3_drop_gnt", ext_gnt, 0);
    check_val("t3_drop_stall", core_stall, 0);
    check_val("t3_drop_we", mem_we, 1);
    next_cyc();
    mid();
    check_val("t3_drop_rvalid", ext_rvalid, 0);
    next_cyc();
`else
    // busy core starves ext indefinitely
    set_core(1, 0, 32'h20, 32'hAAAA5555);
    set_ext(1, 0, 32'h4, 32'h0);
    gnt_cnt = 0;
    stall_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      mid();
      if (ext_gnt) gnt_cnt++;
      if (core_stall) stall_cnt++;
      next_cyc();
    end
    mid();
    check_val("t4_gnt_count", gnt_cnt, 0);
    check_val("t4_stall_count", stall_cnt, 0);
    check_val("t4_core_we", mem_we, 1);
    check_val("t4_rvalid", ext_rvalid, 0);
    next_cyc();
    set_ext(0, 0, 32'h0, 32'h0);
`endif
    set_core(0, 0, 32'h0, 32'h0);
    next_cyc();

    // reset asserted during RESP
    set_ext(1, 0, 32'h100, 32'h0);
    mid();
    check_val("t5_gnt", ext_gnt, 1);
    next_cyc();
    set_ext(0, 0, 32'h0, 32'h0);
    check_val("t5_in_resp", ext_rvalid, 1);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_rvalid", ext_rvalid, 0);
    check_val("t5_rst_rdata", ext_rdata, 32'h0);
    check_val("t5_rst_gnt", ext_gnt, 0);
    mid();
    rst_n = 1'b1;
    next_cyc();
    set_ext(1, 0, 32'h4, 32'h0);
    mid();
    check_val("t5_post_gnt", ext_gnt, 1);
    next_cyc();
    set_ext(0, 0, 32'h0, 32'h0);
    mid();
    check_val("t5_post_rvalid", ext_rvalid, 1);
    check_val("t5_post_rdata", ext_rdata, 32'h12345678);
    next_cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
